// File: rtl/dual_port_blockram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dual_port_blockram_pkg
// Description : Shared constants for the dual-port block RAM: read-during-write
//               mode selectors, init FSM state encodings and a latency
//               legality helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dual_port_blockram_pkg;

   // Read-during-write behaviour selectors (READ_WRITE_MODE)
   localparam int BLOCKRAM_READ_FIRST  = 0;
   localparam int BLOCKRAM_WRITE_FIRST = 1;

   // Init controller state encodings
   localparam logic [0:0] BLOCKRAM_STATE_CLEAR = 1'b0;
   localparam logic [0:0] BLOCKRAM_STATE_READY = 1'b1;

   // Only one- and two-cycle read pipelines are implemented.
   function automatic bit blockram_latency_ok(input int latency);
      return (latency == 1) || (latency == 2);
   endfunction

endpackage
`default_nettype wire

// File: rtl/blockram_init_controller.sv
`default_nettype none
// ============================================================================
// Module      : blockram_init_controller
// Description : CLEAR/READY initialisation sequencer for dual_port_blockram.
//               After reset it walks a pointer over every set, requesting an
//               all-zero write to each, then reports ready.
// Ports       : clk_i            - clock, rising edge
//               reset_n_i        - synchronous active-low reset
//               ready_o          - high once the clear sweep is finished
//               clear_write_en_o - zero-write request for clear_addr_o
//               clear_addr_o     - set currently being cleared
// Revision    : 1.0 - initial release
// ============================================================================
module blockram_init_controller
   import dual_port_blockram_pkg::*;
#(
   parameter int NUMBER_SETS           = 64,
   parameter int SET_PTR_WIDTH_IN_BITS = $clog2(NUMBER_SETS),
   parameter int CLEAR_ON_RESET        = 1
) (
   input  logic                             clk_i,
   input  logic                             reset_n_i,
   output logic                             ready_o,
   output logic                             clear_write_en_o,
   output logic [SET_PTR_WIDTH_IN_BITS-1:0] clear_addr_o
);

   localparam bit c_clear = (CLEAR_ON_RESET != 0);
   localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] c_last_set =
      SET_PTR_WIDTH_IN_BITS'(NUMBER_SETS - 1);

   logic [0:0]                       state_q, state_d;
   logic [SET_PTR_WIDTH_IN_BITS-1:0] ptr_q, ptr_d;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == BLOCKRAM_STATE_CLEAR) begin
         // Without clearing there is nothing to sweep: go ready immediately.
         if (!c_clear || (ptr_q == c_last_set)) begin
            state_d = BLOCKRAM_STATE_READY;
         end else begin
            ptr_d = ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q <= BLOCKRAM_STATE_CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   assign ready_o          = (state_q == BLOCKRAM_STATE_READY);
   // Gated by reset so a reset edge never commits a clear write.
   assign clear_write_en_o = c_clear && reset_n_i && (state_q == BLOCKRAM_STATE_CLEAR);
   assign clear_addr_o     = ptr_q;

endmodule
`default_nettype wire

// File: rtl/dual_port_blockram.sv
`default_nettype none
// ============================================================================
// Module      : dual_port_blockram
// Description : Dual-port block RAM. Port A: masked read/write, port B:
//               read-only. Configurable read latency (1/2), read-first or
//               write-first collision behaviour, self-clearing after reset.
// Ports       : clk_in / reset_in (sync, active-low), ready_out,
//               port A: access_en_a_in, write_en_a_in, write_mask_a_in,
//                       access_set_addr_a_in, write_element_a_in,
//                       read_element_a_out, read_valid_a_out
//               port B: access_en_b_in, access_set_addr_b_in,
//                       read_element_b_out, read_valid_b_out
// Revision    : 1.0 - initial release
// ============================================================================
module dual_port_blockram
   import dual_port_blockram_pkg::*;
#(
   parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
   parameter int NUMBER_SETS                 = 64,
   parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS),
   parameter int WRITE_MASK_WIDTH_IN_BITS    = SINGLE_ELEMENT_SIZE_IN_BITS / 8,
   parameter int READ_LATENCY                = 1,
   parameter int READ_WRITE_MODE             = BLOCKRAM_READ_FIRST,
   parameter int CLEAR_ON_RESET              = 1
) (
   input  logic                                   clk_in,
   input  logic                                   reset_in,
   output logic                                   ready_out,
   input  logic                                   access_en_a_in,
   input  logic                                   write_en_a_in,
   input  logic [WRITE_MASK_WIDTH_IN_BITS-1:0]    write_mask_a_in,
   input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       access_set_addr_a_in,
   input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] write_element_a_in,
   output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] read_element_a_out,
   output logic                                   read_valid_a_out,
   input  logic                                   access_en_b_in,
   input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       access_set_addr_b_in,
   output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] read_element_b_out,
   output logic                                   read_valid_b_out
);

   localparam int DW = SINGLE_ELEMENT_SIZE_IN_BITS;
   localparam int AW = SET_PTR_WIDTH_IN_BITS;
   localparam bit c_write_first = (READ_WRITE_MODE == BLOCKRAM_WRITE_FIRST);

   generate
      if ((SINGLE_ELEMENT_SIZE_IN_BITS % 8) != 0) begin : g_bad_width
         $error("SINGLE_ELEMENT_SIZE_IN_BITS must be a multiple of 8");
      end
      if (!blockram_latency_ok(READ_LATENCY)) begin : g_bad_latency
         $error("READ_LATENCY must be 1 or 2");
      end
   endgenerate

   logic [DW-1:0] mem_q [NUMBER_SETS];

   logic          ready;
   logic          clear_we;
   logic [AW-1:0] clear_addr;

   blockram_init_controller #(
      .NUMBER_SETS           (NUMBER_SETS),
      .SET_PTR_WIDTH_IN_BITS (AW),
      .CLEAR_ON_RESET        (CLEAR_ON_RESET)
   ) u_init (
      .clk_i            (clk_in),
      .reset_n_i        (reset_in),
      .ready_o          (ready),
      .clear_write_en_o (clear_we),
      .clear_addr_o     (clear_addr)
   );

   assign ready_out = ready;

   // ---------------------------------------------------------------- decode
   logic          in_range_a, in_range_b;
   logic          acc_a, acc_b, wr_a, collision;
   logic [DW-1:0] bit_mask, old_a, old_b, merged_a, rd_a_d, rd_b_d;

   generate
      for (genvar i = 0; i < WRITE_MASK_WIDTH_IN_BITS; i++) begin : g_byte_mask
         assign bit_mask[8*i +: 8] = {8{write_mask_a_in[i]}};
      end

      // A power-of-two depth cannot be addressed out of range.
      if (NUMBER_SETS == (1 << AW)) begin : g_range_full
         assign in_range_a = 1'b1;
         assign in_range_b = 1'b1;
      end else begin : g_range_partial
         localparam logic [AW:0] c_num_sets = (AW + 1)'(NUMBER_SETS);
         assign in_range_a = ({1'b0, access_set_addr_a_in} < c_num_sets);
         assign in_range_b = ({1'b0, access_set_addr_b_in} < c_num_sets);
      end
   endgenerate

   assign acc_a     = ready && access_en_a_in;
   assign acc_b     = ready && access_en_b_in;
   assign wr_a      = acc_a && write_en_a_in && in_range_a;
   assign collision = wr_a && in_range_b && (access_set_addr_b_in == access_set_addr_a_in);

   assign old_a    = in_range_a ? mem_q[access_set_addr_a_in] : '0;
   assign old_b    = in_range_b ? mem_q[access_set_addr_b_in] : '0;
   assign merged_a = (old_a & ~bit_mask) | (write_element_a_in & bit_mask);

   always_comb begin
      rd_a_d = old_a;
      if (!in_range_a) begin
         rd_a_d = '0;
      end else if (c_write_first && write_en_a_in) begin
         rd_a_d = merged_a;
      end
   end

   // Port B forwards the merged word only when it hits the set A writes now.
   always_comb begin
      rd_b_d = old_b;
      if (!in_range_b) begin
         rd_b_d = '0;
      end else if (c_write_first && collision) begin
         rd_b_d = merged_a;
      end
   end

   // ---------------------------------------------------------------- array
   always_ff @(posedge clk_in) begin
      if (clear_we) begin
         mem_q[clear_addr] <= '0;
      end else if (wr_a && reset_in) begin
         mem_q[access_set_addr_a_in] <= merged_a;
      end
   end

   // ---------------------------------------------------------------- read pipeline
   logic          s1_valid_a_q, s1_valid_b_q;
   logic [DW-1:0] s1_data_a_q, s1_data_b_q;

   // Data registers load only on a response so outputs hold between responses.
   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         s1_valid_a_q <= 1'b0;
         s1_valid_b_q <= 1'b0;
         s1_data_a_q  <= '0;
         s1_data_b_q  <= '0;
      end else begin
         s1_valid_a_q <= acc_a;
         s1_valid_b_q <= acc_b;
         if (acc_a) s1_data_a_q <= rd_a_d;
         if (acc_b) s1_data_b_q <= rd_b_d;
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic          s2_valid_a_q, s2_valid_b_q;
         logic [DW-1:0] s2_data_a_q, s2_data_b_q;

         always_ff @(posedge clk_in) begin
            if (!reset_in) begin
               s2_valid_a_q <= 1'b0;
               s2_valid_b_q <= 1'b0;
               s2_data_a_q  <= '0;
               s2_data_b_q  <= '0;
            end else begin
               s2_valid_a_q <= s1_valid_a_q;
               s2_valid_b_q <= s1_valid_b_q;
               if (s1_valid_a_q) s2_data_a_q <= s1_data_a_q;
               if (s1_valid_b_q) s2_data_b_q <= s1_data_b_q;
            end
         end

         assign read_valid_a_out   = s2_valid_a_q;
         assign read_valid_b_out   = s2_valid_b_q;
         assign read_element_a_out = s2_data_a_q;
         assign read_element_b_out = s2_data_b_q;
      end else begin : g_lat1
         assign read_valid_a_out   = s1_valid_a_q;
         assign read_valid_b_out   = s1_valid_b_q;
         assign read_element_a_out = s1_data_a_q;
         assign read_element_b_out = s1_data_b_q;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dual_port_blockram.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_port_blockram
// Description : Self-checking bench. Four instances share one stimulus stream:
//               0: latency 1 read-first, 1: latency 1 write-first,
//               2: latency 2 read-first, 3: 40 sets latency 1 read-first.
//               Expected responses come from a per-instance memory model and
//               are queued with their due cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_port_blockram;

   function automatic int ns_of(input int d);  return (d == 3) ? 40 : 64; endfunction
   function automatic int wf_of(input int d);  return (d == 1) ? 1 : 0;   endfunction
   function automatic int lat_of(input int d); return (d == 2) ? 2 : 1;   endfunction

   logic        clk = 1'b0;
   logic        reset_in = 1'b0;
   logic        ae = 1'b0, we = 1'b0, be = 1'b0;
   logic [7:0]  mask = '0;
   logic [5:0]  aa = '0, ab = '0;
   logic [63:0] wd = '0;

   logic        rdy [4];
   logic        va [4];
   logic        vb [4];
   logic [63:0] da [4];
   logic [63:0] db [4];

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < 4; g++) begin : g_dut
         dual_port_blockram #(
            .SINGLE_ELEMENT_SIZE_IN_BITS (64),
            .NUMBER_SETS                 (ns_of(g)),
            .READ_LATENCY                (lat_of(g)),
            .READ_WRITE_MODE             (wf_of(g)),
            .CLEAR_ON_RESET              (1)
         ) u_dut (
            .clk_in               (clk),
            .reset_in             (reset_in),
            .ready_out            (rdy[g]),
            .access_en_a_in       (ae),
            .write_en_a_in        (we),
            .write_mask_a_in      (mask),
            .access_set_addr_a_in (aa),
            .write_element_a_in   (wd),
            .read_element_a_out   (da[g]),
            .read_valid_a_out     (va[g]),
            .access_en_b_in       (be),
            .access_set_addr_b_in (ab),
            .read_element_b_out   (db[g]),
            .read_valid_b_out     (vb[g])
         );
      end
   endgenerate

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [63:0] mdl [4][64];
   // stream s = 2*instance + port (0 = A, 1 = B)
   logic [63:0] exp_q   [8][$];
   int          exp_cyc [8][$];
   logic [63:0] obs_q   [8][$];
   int          obs_cyc [8][$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int d = 0; d < 4; d++) begin
         if (va[d]) begin obs_q[2*d].push_back(da[d]);   obs_cyc[2*d].push_back(cyc);   end
         if (vb[d]) begin obs_q[2*d+1].push_back(db[d]); obs_cyc[2*d+1].push_back(cyc); end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   // Drive one cycle of stimulus and queue what each instance must return.
   task automatic drive(input logic a_en, input logic a_we, input logic [7:0] m,
                        input logic [5:0] a_addr, input logic [63:0] a_data,
                        input logic b_en, input logic [5:0] b_addr);
      logic [63:0] bm, old_a, old_b, mrg, ra, rb;
      bit          a_in, b_in;
      @(posedge clk); #1;
      ae = a_en; we = a_we; mask = m; aa = a_addr; wd = a_data; be = b_en; ab = b_addr;
      for (int i = 0; i < 8; i++) bm[8*i +: 8] = {8{m[i]}};
      for (int d = 0; d < 4; d++) begin
         a_in  = int'(a_addr) < ns_of(d);
         b_in  = int'(b_addr) < ns_of(d);
         old_a = a_in ? mdl[d][a_addr] : 64'h0;
         old_b = b_in ? mdl[d][b_addr] : 64'h0;
         mrg   = (old_a & ~bm) | (a_data & bm);
         ra    = !a_in ? 64'h0 : ((wf_of(d) == 1) && a_we) ? mrg : old_a;
         rb    = !b_in ? 64'h0 :
                 ((wf_of(d) == 1) && a_en && a_we && a_in && (b_addr == a_addr)) ? mrg : old_b;
         if (a_en) begin exp_q[2*d].push_back(ra);   exp_cyc[2*d].push_back(cyc + lat_of(d));   end
         if (b_en) begin exp_q[2*d+1].push_back(rb); exp_cyc[2*d+1].push_back(cyc + lat_of(d)); end
         if (a_en && a_we && a_in) mdl[d][a_addr] = mrg;
      end
   endtask

   task automatic test_reset();
      int first [4];
      for (int d = 0; d < 4; d++) begin
         first[d] = 0;
         for (int s = 0; s < 64; s++) mdl[d][s] = 64'h0;
      end
      reset_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
         total++;
         if ({rdy[d], va[d], vb[d], da[d], db[d]} !== 131'h0) begin
            bad++;
            $display("FAIL reset_state dut=%0d got rdy=%b va=%b vb=%b da=%h db=%h want all zero",
                     d, rdy[d], va[d], vb[d], da[d], db[d]);
         end
      end
      reset_in = 1'b1;
      for (int n = 1; n <= 70; n++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 4; d++) if (rdy[d] && first[d] == 0) first[d] = n;
      end
      for (int d = 0; d < 4; d++) begin
         total++;
         if (first[d] !== ns_of(d)) begin
            bad++;
            $display("FAIL clear_time dut=%0d got=%0d want=%0d", d, first[d], ns_of(d));
         end
      end
   endtask

   task automatic test_reset_mid_clear();
      int first [4];
      bit early;
      early = 0;
      @(posedge clk); #1; reset_in = 1'b0;
      @(posedge clk); #1; reset_in = 1'b1;
      // Accesses while not ready must be ignored by every instance.
      for (int n = 1; n <= 29; n++) begin
         @(posedge clk); #1;
         ae = (n >= 3 && n <= 8); we = ae; be = ae; mask = 8'hFF;
         aa = 6'(n); ab = 6'(n); wd = '1;
         for (int d = 0; d < 4; d++) if (rdy[d]) early = 1;
      end
      ae = 0; we = 0; be = 0;
      reset_in = 1'b0;
      @(posedge clk); #1;
      reset_in = 1'b1;
      for (int d = 0; d < 4; d++) begin
         first[d] = 0;
         if (rdy[d]) early = 1;
      end
      total++;
      if (early) begin
         bad++;
         $display("FAIL mid_clear_ready_early got=1 want=0");
      end
      for (int n = 1; n <= 70; n++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 4; d++) if (rdy[d] && first[d] == 0) first[d] = n;
      end
      for (int d = 0; d < 4; d++) begin
         total++;
         if (first[d] !== ns_of(d)) begin
            bad++;
            $display("FAIL mid_clear_time dut=%0d got=%0d want=%0d", d, first[d], ns_of(d));
         end
      end
      for (int s = 0; s < 8; s++) begin
         total++;
         if (obs_q[s].size() != 0) begin
            bad++;
            $display("FAIL not_ready_gating stream=%0d got=%0d responses want=0", s, obs_q[s].size());
         end
         obs_q[s].delete(); obs_cyc[s].delete();
      end
   endtask

   task automatic test_clear();
      logic [63:0] o, e;
      int oc, ec;
      for (int s = 0; s < 64; s++) drive(0, 0, 8'h00, 6'd0, 64'h0, 1, 6'(s));
      @(posedge clk); #1; ae = 0; we = 0; be = 0;
      repeat (4) @(posedge clk);
      #1;
      for (int s = 0; s < 8; s++) begin
         total++;
         if (obs_q[s].size() != exp_q[s].size()) begin
            bad++;
            $display("FAIL clear_count stream=%0d got=%0d want=%0d", s, obs_q[s].size(), exp_q[s].size());
         end
         while (obs_q[s].size() > 0 && exp_q[s].size() > 0) begin
            o = obs_q[s].pop_front(); oc = obs_cyc[s].pop_front();
            e = exp_q[s].pop_front(); ec = exp_cyc[s].pop_front();
            total++;
            if (o !== e || oc !== ec) begin
               bad++;
               $display("FAIL clear_read stream=%0d got=%h@%0d want=%h@%0d", s, o, oc, e, ec);
            end
         end
         obs_q[s].delete(); obs_cyc[s].delete(); exp_q[s].delete(); exp_cyc[s].delete();
      end
   endtask

   task automatic test_masked_write();
      logic [63:0] o, e;
      int oc, ec;
      drive(1, 1, 8'hFF, 6'd63, 64'hFFFF_FFFF_0000_0000, 0, 6'd0);
      drive(1, 1, 8'h0F, 6'd63, 64'h0000_0000_1234_5678, 0, 6'd0);
      drive(0, 0, 8'h00, 6'd0,  64'h0, 1, 6'd63);
      drive(1, 1, 8'hA5, 6'd7,  64'h1111_2222_3333_4444, 0, 6'd0);
      drive(1, 1, 8'h00, 6'd7,  64'hFFFF_FFFF_FFFF_FFFF, 1, 6'd7);
      drive(0, 0, 8'h00, 6'd0,  64'h0, 1, 6'd7);
      @(posedge clk); #1; ae = 0; we = 0; be = 0;
      repeat (4) @(posedge clk);
      #1;
      for (int s = 0; s < 8; s++) begin
         total++;
         if (obs_q[s].size() != exp_q[s].size()) begin
            bad++;
            $display("FAIL masked_count stream=%0d got=%0d want=%0d", s, obs_q[s].size(), exp_q[s].size());
         end
         while (obs_q[s].size() > 0 && exp_q[s].size() > 0) begin
            o = obs_q[s].pop_front(); oc = obs_cyc[s].pop_front();
            e = exp_q[s].pop_front(); ec = exp_cyc[s].pop_front();
            total++;
            if (o !== e || oc !== ec) begin
               bad++;
               $display("FAIL masked_read stream=%0d got=%h@%0d want=%h@%0d", s, o, oc, e, ec);
            end
         end
         obs_q[s].delete(); obs_cyc[s].delete(); exp_q[s].delete(); exp_cyc[s].delete();
      end
   endtask

   task automatic test_collision();
      logic [63:0] o, e;
      int oc, ec;
      drive(1, 1, 8'hFF, 6'd5, 64'hA, 0, 6'd0);
      drive(1, 1, 8'hFF, 6'd5, 64'hB, 1, 6'd5);
      drive(0, 0, 8'h00, 6'd0, 64'h0, 1, 6'd5);
      drive(1, 1, 8'h03, 6'd6, 64'hCAFE, 1, 6'd9);
      drive(1, 1, 8'h01, 6'd5, 64'hFFFF, 1, 6'd5);
      @(posedge clk); #1; ae = 0; we = 0; be = 0;
      repeat (4) @(posedge clk);
      #1;
      for (int s = 0; s < 8; s++) begin
         total++;
         if (obs_q[s].size() != exp_q[s].size()) begin
            bad++;
            $display("FAIL collision_count stream=%0d got=%0d want=%0d", s, obs_q[s].size(), exp_q[s].size());
         end
         while (obs_q[s].size() > 0 && exp_q[s].size() > 0) begin
            o = obs_q[s].pop_front(); oc = obs_cyc[s].pop_front();
            e = exp_q[s].pop_front(); ec = exp_cyc[s].pop_front();
            total++;
            if (o !== e || oc !== ec) begin
               bad++;
               $display("FAIL collision_read stream=%0d got=%h@%0d want=%h@%0d", s, o, oc, e, ec);
            end
         end
         obs_q[s].delete(); obs_cyc[s].delete(); exp_q[s].delete(); exp_cyc[s].delete();
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] o, e;
      int oc, ec;
      for (int s = 1; s <= 3; s++) drive(1, 1, 8'hFF, 6'(s), 64'h100 + 64'(s), 0, 6'd0);
      for (int s = 1; s <= 3; s++) drive(1, 0, 8'h00, 6'(4 - s), 64'h0, 1, 6'(s));
      @(posedge clk); #1; ae = 0; we = 0; be = 0;
      repeat (4) @(posedge clk);
      #1;
      for (int s = 0; s < 8; s++) begin
         total++;
         if (obs_q[s].size() != exp_q[s].size()) begin
            bad++;
            $display("FAIL b2b_count stream=%0d got=%0d want=%0d", s, obs_q[s].size(), exp_q[s].size());
         end
         while (obs_q[s].size() > 0 && exp_q[s].size() > 0) begin
            o = obs_q[s].pop_front(); oc = obs_cyc[s].pop_front();
            e = exp_q[s].pop_front(); ec = exp_cyc[s].pop_front();
            total++;
            if (o !== e || oc !== ec) begin
               bad++;
               $display("FAIL b2b_read stream=%0d got=%h@%0d want=%h@%0d", s, o, oc, e, ec);
            end
         end
         obs_q[s].delete(); obs_cyc[s].delete(); exp_q[s].delete(); exp_cyc[s].delete();
      end
      // Idle outputs keep the last response data: A read set 1 last, B set 3.
      for (int d = 0; d < 4; d++) begin
         total++;
         if (da[d] !== mdl[d][1] || db[d] !== mdl[d][3] || va[d] !== 1'b0 || vb[d] !== 1'b0) begin
            bad++;
            $display("FAIL hold dut=%0d got da=%h db=%h va=%b vb=%b want da=%h db=%h va=0 vb=0",
                     d, da[d], db[d], va[d], vb[d], mdl[d][1], mdl[d][3]);
         end
      end
   endtask

   task automatic test_gating();
      logic [63:0] o, e;
      int oc, ec;
      drive(0, 1, 8'hFF, 6'd10, 64'hFFFF_FFFF_FFFF_FFFF, 0, 6'd0);
      drive(0, 0, 8'h00, 6'd0, 64'h0, 1, 6'd10);
      @(posedge clk); #1; ae = 0; we = 0; be = 0;
      repeat (4) @(posedge clk);
      #1;
      for (int s = 0; s < 8; s++) begin
         total++;
         if (obs_q[s].size() != exp_q[s].size()) begin
            bad++;
            $display("FAIL gating_count stream=%0d got=%0d want=%0d", s, obs_q[s].size(), exp_q[s].size());
         end
         while (obs_q[s].size() > 0 && exp_q[s].size() > 0) begin
            o = obs_q[s].pop_front(); oc = obs_cyc[s].pop_front();
            e = exp_q[s].pop_front(); ec = exp_cyc[s].pop_front();
            total++;
            if (o !== e || oc !== ec) begin
               bad++;
               $display("FAIL gating_read stream=%0d got=%h@%0d want=%h@%0d", s, o, oc, e, ec);
            end
         end
         obs_q[s].delete(); obs_cyc[s].delete(); exp_q[s].delete(); exp_cyc[s].delete();
      end
   endtask

   task automatic test_out_of_range();
      logic [63:0] o, e;
      int oc, ec;
      drive(1, 1, 8'hFF, 6'd45, 64'hDEAD, 0, 6'd0);
      drive(1, 1, 8'hFF, 6'd39, 64'hBEEF, 1, 6'd45);
      drive(1, 0, 8'h00, 6'd45, 64'h0, 1, 6'd39);
      drive(1, 1, 8'hFF, 6'd40, 64'h5555, 1, 6'd40);
      @(posedge clk); #1; ae = 0; we = 0; be = 0;
      repeat (4) @(posedge clk);
      #1;
      for (int s = 0; s < 8; s++) begin
         total++;
         if (obs_q[s].size() != exp_q[s].size()) begin
            bad++;
            $display("FAIL range_count stream=%0d got=%0d want=%0d", s, obs_q[s].size(), exp_q[s].size());
         end
         while (obs_q[s].size() > 0 && exp_q[s].size() > 0) begin
            o = obs_q[s].pop_front(); oc = obs_cyc[s].pop_front();
            e = exp_q[s].pop_front(); ec = exp_cyc[s].pop_front();
            total++;
            if (o !== e || oc !== ec) begin
               bad++;
               $display("FAIL range_read stream=%0d got=%h@%0d want=%h@%0d", s, o, oc, e, ec);
            end
         end
         obs_q[s].delete(); obs_cyc[s].delete(); exp_q[s].delete(); exp_cyc[s].delete();
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_clear();
      test_clear();
      test_masked_write();
      test_collision();
      test_back_to_back();
      test_gating();
      test_out_of_range();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dual_port_blockram.md
# dual_port_blockram

Parametrised dual-port block RAM, the successor to the single-port block RAM used by cache tag/data arrays. Port A performs masked read/write accesses and port B is read-only. The block has configurable read latency and read-during-write semantics, plus a self-clearing initialisation sequence after reset. It sits under the cache and TLB arrays wherever a lookup port and a fill/update port must run in the same cycle.

## Interface
- SINGLE_ELEMENT_SIZE_IN_BITS, 64: word width; must be a multiple of 8 (elaboration `$error` otherwise)
- NUMBER_SETS, 64: depth; need not be a power of two
- SET_PTR_WIDTH_IN_BITS, $clog2(NUMBER_SETS): address width
- WRITE_MASK_WIDTH_IN_BITS, SINGLE_ELEMENT_SIZE_IN_BITS/8: byte-enable width
- READ_LATENCY, 1: 1 or 2 cycles; any other value is an elaboration error
- READ_WRITE_MODE, 0: 0 = read-first, 1 = write-first
- CLEAR_ON_RESET, 1: 1 = zero every set after reset
- clk_in  input  1  clock; all logic is on the rising edge
- reset_in  input  1  reset, synchronous, active-low
- ready_out  output  1  high once initialisation completes; accesses are ignored while low
- access_en_a_in  input  1  port A access request
- write_en_a_in  input  1  port A write; valid only with access_en_a_in
- write_mask_a_in  input  WRITE_MASK_WIDTH_IN_BITS  bit i enables bits [8i+7:8i]
- access_set_addr_a_in  input  SET_PTR_WIDTH_IN_BITS  port A address
- write_element_a_in  input  SINGLE_ELEMENT_SIZE_IN_BITS  port A write data
- read_element_a_out  output  SINGLE_ELEMENT_SIZE_IN_BITS  port A read data
- read_valid_a_out  output  1  port A read data valid
- access_en_b_in  input  1  port B read request
- access_set_addr_b_in  input  SET_PTR_WIDTH_IN_BITS  port B address
- read_element_b_out  output  SINGLE_ELEMENT_SIZE_IN_BITS  port B read data
- read_valid_b_out  output  1  port B read data valid

## Operation
- Init FSM states: CLEAR, READY.
  - reset_in low at an edge: state becomes CLEAR and clear pointer becomes 0.
  - In CLEAR, each edge writes all-zero to the pointed set and increments the pointer.
  - The write to set NUMBER_SETS-1 moves the FSM to READY.
  - With CLEAR_ON_RESET=0, the first edge with reset_in high moves the FSM straight to READY; memory contents are then undefined.
  - Reset asserted during CLEAR restarts the sequence from set 0.
- Reset values: ready_out=0, read_valid_*=0, read_element_*=0, and any latency-2 pipeline registers=0.
- An access is accepted only in READY with access_en high.
  - Every accepted port A access, write or not, produces one read response.
  - Every accepted port B access produces one read response.
- Masked write: the stored word becomes (old & ~M) | (data & M), where M is write_mask_a_in expanded to bytes. An all-zero mask is a legal no-op write that still returns a response.
- Read-during-write, for port A's own write and for port B reading the address A writes in the same cycle:
  - Read-first: the response returns the pre-write word.
  - Write-first: the response returns the merged post-write word.
- Out-of-range address (>= NUMBER_SETS):
  - The write is dropped.
  - The read returns 0 with valid asserted.
- Outputs hold the last data between responses; only read_valid_* deasserts.
- write_en_a_in without access_en_a_in is ignored.

## Timing
- Clear duration: ready_out rises at the NUMBER_SETS-th edge with reset_in high. The first access is accepted at the following edge.
- Read latency:
  - Request sampled at edge k, READ_LATENCY=1: data and valid update at edge k and are visible in cycle k+1.
  - READ_LATENCY=2: they update at edge k+1.
- Back-to-back accesses on either port are accepted every cycle; responses come out in order, one per cycle.
- read_valid_* is a single-cycle pulse per response.
- Reset mid-pipeline:
  - In-flight responses are discarded.
  - Valid outputs are 0 from the reset edge.
  - Memory contents are not preserved when CLEAR_ON_RESET=1.

## Structure
- parameters.h gains BLOCKRAM_READ_FIRST=0, BLOCKRAM_WRITE_FIRST=1 and the init state encodings BLOCKRAM_STATE_CLEAR and BLOCKRAM_STATE_READY.
- Sub-module blockram_init_controller contains the CLEAR/READY FSM and pointer. It outputs ready, clear_write_en and clear_addr.
- The memory array, byte-merge logic, collision forwarding and latency pipeline stay in dual_port_blockram.

## Test plan
- Clear check: hold reset_in low for 2 cycles, then release. ready_out must rise after exactly 64 cycles, and a port B read of each set 0..63 must return 0 with valid.
- Masked write, 64-bit width: write 0xFFFF_FFFF_0000_0000 to set 63 with mask 0xFF. Then write 0x0000_0000_1234_5678 to set 63 with mask 0x0F. A port B read of set 63 must return 0xFFFF_FFFF_1234_5678.
- Collision, READ_WRITE_MODE=0: set 5 holds 0xA. Port A writes 0xB to set 5 (mask 0xFF) while port B reads set 5 in the same cycle. Both responses must be 0xA, and the next port B read must return 0xB. Repeat with READ_WRITE_MODE=1: both responses must be 0xB.
- Latency: with READ_LATENCY=2, issue port B reads of sets 1, 2, 3 back-to-back. The data must appear in order on consecutive cycles, starting 2 cycles after the first request, each with a one-cycle valid.
- Gating: an access asserted while ready_out=0, and a write_en_a_in pulse with access_en_a_in=0, must produce no valid and no memory change.
- Reset mid-clear: assert reset_in at clear cycle 30. ready_out must stay low and rise exactly 64 cycles after the release.
